// File: rtl/spi_slave_param.sv
// spi_slave_param: parametrised SPI slave bridging an SPI master to the on-chip RAM port.
// The SPI bit clock is clk itself; every port is synchronous to its rising edge.
// A frame is one mode bit followed by F = DATA_W+2 bits ({cmd[1:0], payload}, MSB first).
// Mode 0 performs a write. Mode 1 performs a read address, or a read data transfer
// when a read address is already pending.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   SS_n         slave select, active low
//   MOSI / MISO  serial data in / out, MSB first
//   rx_data      last completed frame {cmd, payload}; rx_valid pulses once per frame
//   tx_data      RAM read data, accepted with tx_valid in WAIT_TX only
//   frame_err    pulse: SS_n rose before the frame completed
//   tx_timeout   pulse: tx_valid did not arrive within TX_TIMEOUT cycles
//   busy         state != IDLE
module spi_slave_param #(
  parameter int DATA_W     = 8,
  parameter int TX_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              frame_err,
  output logic              tx_timeout,
  output logic              busy
);

  localparam int F     = DATA_W + 2;
  localparam int CNT_W = $clog2(F);
  localparam int TMO_W = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;

  localparam logic [CNT_W-1:0] RX_LAST  = CNT_W'(F - 1);
  localparam logic [CNT_W-1:0] TX_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TX_TIMEOUT > 0) ? TX_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, SHIFT_TX, DONE
  } state_t;

  state_t            state, state_next;
  logic              rd_addr_flag;
  logic [CNT_W-1:0]  bit_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  // Holds the first F-1 frame bits; the final bit is taken directly from MOSI.
  logic [F-2:0]      rx_shift;
  logic [DATA_W-1:0] tx_shift;

  logic in_rx, abort, frame_done, tmo_hit;

  always_comb begin
    in_rx      = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
    abort      = SS_n && (state != IDLE) && (state != DONE);
    frame_done = in_rx && !SS_n && (bit_cnt == RX_LAST);
    tmo_hit    = (TX_TIMEOUT > 0) && (state == WAIT_TX) && !SS_n && !tx_valid
                 && (tmo_cnt == TMO_LAST);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (!SS_n) state_next = CHK_CMD;
      CHK_CMD:  if (SS_n) state_next = IDLE;
                else if (MOSI) state_next = rd_addr_flag ? READ_DATA : READ_ADD;
                else state_next = WRITE;
      WRITE, READ_ADD, READ_DATA:
                if (SS_n) state_next = IDLE;
                else if (frame_done) state_next = (state == READ_DATA) ? WAIT_TX : DONE;
      WAIT_TX:  if (SS_n) state_next = IDLE;
                else if (tx_valid) state_next = SHIFT_TX;
                else if (tmo_hit) state_next = DONE;
      SHIFT_TX: if (SS_n) state_next = IDLE;
                else if (bit_cnt == TX_LAST) state_next = DONE;
      DONE:     if (SS_n) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rd_addr_flag <= 1'b0;
      bit_cnt      <= '0;
      tmo_cnt      <= '0;
      rx_shift     <= '0;
      tx_shift     <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      frame_err    <= 1'b0;
      tx_timeout   <= 1'b0;
      MISO         <= 1'b0;
    end else begin
      state      <= state_next;
      rx_valid   <= 1'b0;
      frame_err  <= abort;
      tx_timeout <= tmo_hit;
      if (abort) begin
        MISO <= 1'b0;
      end else begin
        case (state)
          CHK_CMD: begin
            bit_cnt <= '0;
          end
          WRITE, READ_ADD, READ_DATA: begin
            rx_shift <= {rx_shift[F-3:0], MOSI};
            bit_cnt  <= bit_cnt + 1'b1;
            tmo_cnt  <= '0;
            if (frame_done) begin
              rx_data  <= {rx_shift, MOSI};
              rx_valid <= 1'b1;
              if (state == READ_ADD) rd_addr_flag <= 1'b1;
            end
          end
          WAIT_TX: begin
            if (tx_valid) begin
              // MSB goes out on the accepting edge; the rest follow from tx_shift.
              MISO     <= tx_data[DATA_W-1];
              tx_shift <= tx_data << 1;
              bit_cnt  <= '0;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
              if (tmo_hit) rd_addr_flag <= 1'b0;
            end
          end
          SHIFT_TX: begin
            if (bit_cnt == TX_LAST) begin
              MISO         <= 1'b0;
              rd_addr_flag <= 1'b0;
            end else begin
              MISO     <= tx_shift[DATA_W-1];
              tx_shift <= tx_shift << 1;
              bit_cnt  <= bit_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
